// File: rtl/spi_flash_xip_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_flash_xip_reader: mode-0 SPI master issuing a 03h read of one 32-bit |
// | word per request. Optional SPI_FLASH_XIP_BSWAP_EN byte-swaps the result. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_flash_xip_reader #(
   parameter int         DIV = 2,
   parameter logic [7:0] CMD = 8'h03
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        busy,
   output logic        sck,
   output logic        ss,
   output logic        mosi,
   input  logic        miso
);
   localparam logic [1:0] c_idle     = 2'd0;
   localparam logic [1:0] c_shift    = 2'd1;
   localparam logic [1:0] c_resp     = 2'd2;
   localparam logic [1:0] c_gap      = 2'd3;
   localparam logic [7:0] c_div_last = 8'(DIV - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic [31:0] r_tx;
   logic [31:0] r_rx;
   logic [31:0] r_resp_data;
   logic [6:0]  r_n;
   logic [7:0]  r_div;
   logic        r_sck;
   logic        r_ss;
   logic        r_resp_valid;
   logic        w_div_exp;
   logic [31:0] w_word;

   assign w_div_exp = (r_div == c_div_last);

`ifdef SPI_FLASH_XIP_BSWAP_EN
   assign w_word = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
`else
   assign w_word = r_rx;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (req_valid) w_next = c_shift;
         c_shift: if (w_div_exp && r_sck && (r_n == 7'd63)) w_next = c_resp;
         c_resp:  if (resp_ready) w_next = c_gap;
         c_gap:   if (w_div_exp) w_next = c_idle;
         default: w_next = c_idle;
      endcase
   end

   always_comb begin
      req_ready = (r_state == c_idle);
      busy      = (r_state != c_idle);
   end

   // tx shifts in zeros, so mosi falls to 0 by itself for the data phase and idle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_tx         <= '0;
         r_rx         <= '0;
         r_resp_data  <= '0;
         r_n          <= '0;
         r_div        <= '0;
         r_sck        <= 1'b0;
         r_ss         <= 1'b1;
         r_resp_valid <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (req_valid) begin
                  r_tx  <= {CMD, req_addr};
                  r_n   <= '0;
                  r_div <= '0;
                  r_ss  <= 1'b0;
                  r_sck <= 1'b0;
               end
            end
            c_shift: begin
               if (!w_div_exp) begin
                  r_div <= r_div + 8'd1;
               end else begin
                  r_div <= '0;
                  if (!r_sck) begin
                     r_sck <= 1'b1;
                     if (r_n[5]) r_rx <= {r_rx[30:0], miso};
                  end else begin
                     r_sck <= 1'b0;
                     if (r_n == 7'd63) begin
                        r_ss         <= 1'b1;
                        r_resp_data  <= w_word;
                        r_resp_valid <= 1'b1;
                     end else begin
                        r_n  <= r_n + 7'd1;
                        r_tx <= {r_tx[30:0], 1'b0};
                     end
                  end
               end
            end
            c_resp: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_div        <= '0;
               end
            end
            c_gap: begin
               if (!w_div_exp) r_div <= r_div + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign sck        = r_sck;
   assign ss         = r_ss;
   assign mosi       = r_tx[31];
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_xip_reader.sv
`default_nettype none
// Bench for spi_flash_xip_reader: behavioural 03h flash, randomized traffic,
// queue scoreboard checked by a decoupled response monitor.
module tb_spi_flash_xip_reader;
   localparam int         DIV_A    = 2;
   localparam int         DIV_B    = 1;
   localparam logic [7:0] READ_CMD = 8'h03;

   typedef struct {
      logic [31:0] word;
      logic [31:0] frame;
      int          t;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_busy;
   logic        a_sck, a_ss, a_mosi, a_miso;
   logic [23:0] a_req_addr;
   logic [31:0] a_resp_data;
   logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_busy;
   logic        b_sck, b_ss, b_mosi, b_miso;
   logic [23:0] b_req_addr;
   logic [31:0] b_resp_data;

   spi_flash_xip_reader #(.DIV(DIV_A), .CMD(READ_CMD)) u_dut_a (
      .clock(clk), .reset_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_addr(a_req_addr), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_data(a_resp_data), .busy(a_busy), .sck(a_sck), .ss(a_ss), .mosi(a_mosi),
      .miso(a_miso));

   spi_flash_xip_reader #(.DIV(DIV_B), .CMD(READ_CMD)) u_dut_b (
      .clock(clk), .reset_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_data(b_resp_data), .busy(b_busy), .sck(b_sck), .ss(b_ss), .mosi(b_mosi),
      .miso(b_miso));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no event within bound, required the event", name);
   endtask

   // Flash contents: known bytes at 0x100, a scrambled pattern elsewhere.
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      case (a)
         24'h000100: return 8'h11;
         24'h000101: return 8'h22;
         24'h000102: return 8'h33;
         24'h000103: return 8'h44;
         default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] model_word(input logic [23:0] a);
      logic [7:0] b0, b1, b2, b3;
      b0 = mem_byte(a);
      b1 = mem_byte(a + 24'd1);
      b2 = mem_byte(a + 24'd2);
      b3 = mem_byte(a + 24'd3);
`ifdef SPI_FLASH_XIP_BSWAP_EN
      return {b3, b2, b1, b0};
`else
      return {b0, b1, b2, b3};
`endif
   endfunction

   // Flash models: count rises, capture cmd+addr, drive data on falling sck.
   int          a_cnt = 0, a_last_cnt = 0, a_bad_cmd = 0, a_k = 0;
   logic [31:0] a_sh = '0, a_last_sh = '0;
   logic [7:0]  a_byte;
   always @(posedge a_sck or negedge a_sck or posedge a_ss) begin
      if (a_ss) begin
         if (a_cnt != 0) begin a_last_cnt = a_cnt; a_last_sh = a_sh; end
         a_cnt  = 0;
         a_miso = 1'b0;
      end else if (a_sck) begin
         if (a_cnt < 32) a_sh = {a_sh[30:0], a_mosi};
         a_cnt++;
         if (a_cnt == 8 && a_sh[7:0] != 8'h03) a_bad_cmd++;
      end else if (a_cnt >= 32 && a_cnt < 64) begin
         a_k    = a_cnt - 32;
         a_byte = mem_byte(a_sh[23:0] + 24'(a_k / 8));
         a_miso = a_byte[7 - (a_k % 8)];
      end
   end

   int          b_cnt = 0, b_last_cnt = 0, b_bad_cmd = 0, b_k = 0;
   logic [31:0] b_sh = '0, b_last_sh = '0;
   logic [7:0]  b_byte;
   always @(posedge b_sck or negedge b_sck or posedge b_ss) begin
      if (b_ss) begin
         if (b_cnt != 0) begin b_last_cnt = b_cnt; b_last_sh = b_sh; end
         b_cnt  = 0;
         b_miso = 1'b0;
      end else if (b_sck) begin
         if (b_cnt < 32) b_sh = {b_sh[30:0], b_mosi};
         b_cnt++;
         if (b_cnt == 8 && b_sh[7:0] != 8'h03) b_bad_cmd++;
      end else if (b_cnt >= 32 && b_cnt < 64) begin
         b_k    = b_cnt - 32;
         b_byte = mem_byte(b_sh[23:0] + 24'(b_k / 8));
         b_miso = b_byte[7 - (b_k % 8)];
      end
   end

   // Pin rules: ss/mosi never move while sck is high; every in-frame half-period is DIV clocks.
   logic a_psck = 1'b0, a_pss = 1'b1, a_pmosi = 1'b0;
   logic b_psck = 1'b0, b_pss = 1'b1, b_pmosi = 1'b0;
   int   a_run = 0, a_pin_viol = 0, b_run = 0, b_pin_viol = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if ((a_ss != a_pss || a_mosi != a_pmosi) && a_sck) a_pin_viol++;
         if (a_sck != a_psck && !a_pss && a_run != DIV_A) a_pin_viol++;
         if ((b_ss != b_pss || b_mosi != b_pmosi) && b_sck) b_pin_viol++;
         if (b_sck != b_psck && !b_pss && b_run != DIV_B) b_pin_viol++;
      end
      if (a_sck != a_psck || a_ss != a_pss) a_run = 1; else a_run++;
      if (b_sck != b_psck || b_ss != b_pss) b_run = 1; else b_run++;
      a_psck = a_sck; a_pss = a_ss; a_pmosi = a_mosi;
      b_psck = b_sck; b_pss = b_ss; b_pmosi = b_mosi;
   end

   // Request side of the scoreboard: every accepted request pushes its expectation.
   exp_t a_q[$];
   exp_t b_q[$];
   exp_t a_e, b_e;
   int   a_resp_hs_cyc = 0;
   logic a_b2b_chk = 1'b0;
   always @(posedge clk) begin
      if (rst_n && a_req_valid && a_req_ready) begin
         a_e.word  = model_word(a_req_addr);
         a_e.frame = {READ_CMD, a_req_addr};
         a_e.t     = cyc;
         a_q.push_back(a_e);
         chk("a_ss_high_at_accept", 32'(a_ss), 32'd1);
         if (a_b2b_chk) chk("a_gap_before_accept", cyc - a_resp_hs_cyc, DIV_A + 1);
      end
      if (rst_n && a_resp_valid && a_resp_ready) a_resp_hs_cyc = cyc;
      if (rst_n && b_req_valid && b_req_ready) begin
         b_e.word  = model_word(b_req_addr);
         b_e.frame = {READ_CMD, b_req_addr};
         b_e.t     = cyc;
         b_q.push_back(b_e);
      end
   end

   // Response monitors: pop and compare when resp_valid appears, randomize backpressure.
   exp_t        a_cur, b_cur;
   logic        a_seen = 1'b0, b_seen = 1'b0;
   logic [31:0] a_held = '0;
   int          a_hold = 0, a_hold_tgt = 0, a_force_hold = -1;
   always @(negedge clk) begin
      if (!rst_n) begin
         a_seen       = 1'b0;
         a_resp_ready = 1'b0;
         a_q.delete();
      end else begin
         if (a_q.size() != 0 && a_q[$].t == cyc - 1) begin
            chk("a_ss_low_after_accept", 32'(a_ss), 32'd0);
            chk("a_busy_after_accept", 32'(a_busy), 32'd1);
         end
         if (!a_resp_valid) begin
            a_seen       = 1'b0;
            a_resp_ready = 1'($urandom_range(0, 1));
         end else if (!a_seen) begin
            a_seen     = 1'b1;
            a_held     = a_resp_data;
            a_hold     = 0;
            a_hold_tgt = (a_force_hold >= 0) ? a_force_hold : int'($urandom_range(0, 3));
            if (a_q.size() == 0) begin
               fail("a_resp_unexpected");
            end else begin
               a_cur = a_q.pop_front();
               chk("a_resp_data", a_resp_data, a_cur.word);
               chk("a_resp_latency", cyc - a_cur.t, 128 * DIV_A + 1);
               chk("a_sck_rises", a_last_cnt, 64);
               chk("a_mosi_cmd_addr", a_last_sh, a_cur.frame);
            end
            a_resp_ready = (a_hold >= a_hold_tgt);
         end else begin
            chk("a_hold_data", a_resp_data, a_held);
            chk("a_hold_ss", 32'(a_ss), 32'd1);
            chk("a_hold_req_ready", 32'(a_req_ready), 32'd0);
            a_hold++;
            a_resp_ready = (a_hold >= a_hold_tgt);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         b_seen = 1'b0;
         b_q.delete();
      end else if (!b_resp_valid) begin
         b_seen = 1'b0;
      end else if (!b_seen) begin
         b_seen = 1'b1;
         if (b_q.size() == 0) begin
            fail("b_resp_unexpected");
         end else begin
            b_cur = b_q.pop_front();
            chk("b_resp_data", b_resp_data, b_cur.word);
            chk("b_resp_latency", cyc - b_cur.t, 128 * DIV_B + 1);
            chk("b_sck_rises", b_last_cnt, 64);
            chk("b_mosi_cmd_addr", b_last_sh, b_cur.frame);
         end
      end
   end

   task automatic send_a(input logic [23:0] addr);
      int k = 0;
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_addr  = addr;
      while (!a_req_ready && k < 4000) begin @(negedge clk); k++; end
      if (!a_req_ready) fail("a_req_accept");
      @(negedge clk);
      a_req_valid = 1'b0;
      a_req_addr  = 24'($urandom);
   endtask

   task automatic wait_idle_a();
      int k = 0;
      do begin @(negedge clk); k++; end while ((a_busy || a_q.size() != 0) && k < 4000);
      if (a_busy || a_q.size() != 0) fail("a_wait_idle");
   endtask

   task automatic send_b(input logic [23:0] addr);
      int k = 0;
      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_addr  = addr;
      while (!b_req_ready && k < 4000) begin @(negedge clk); k++; end
      if (!b_req_ready) fail("b_req_accept");
      @(negedge clk);
      b_req_valid = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while ((b_busy || b_q.size() != 0) && k < 4000);
      if (b_busy || b_q.size() != 0) fail("b_wait_idle");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit, required test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      a_req_valid  = 1'b0;
      a_req_addr   = '0;
      b_req_valid  = 1'b0;
      b_req_addr   = '0;
      b_resp_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sck", 32'(a_sck), 32'd0);
      chk("rst_ss", 32'(a_ss), 32'd1);
      chk("rst_mosi", 32'(a_mosi), 32'd0);
      chk("rst_req_ready", 32'(a_req_ready), 32'd1);
      chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
      chk("rst_resp_data", a_resp_data, 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      send_a(24'h000100);
      wait_idle_a();

      a_force_hold = 20;
      send_a(24'h000100);
      wait_idle_a();
      a_force_hold = -1;

      // Back-to-back: req_valid stays high, second request must wait out the gap.
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_addr  = 24'h000000;
      @(negedge clk);
      a_req_addr  = 24'h000004;
      k = 0;
      while (!a_resp_valid && k < 1000) begin @(negedge clk); k++; end
      if (!a_resp_valid) fail("a_b2b_first_resp");
      a_b2b_chk = 1'b1;
      k = 0;
      while (!a_req_ready && k < 1000) begin @(negedge clk); k++; end
      if (!a_req_ready) fail("a_b2b_reaccept");
      @(negedge clk);
      a_req_valid = 1'b0;
      a_b2b_chk   = 1'b0;
      wait_idle_a();

      // Reset in the data phase, then a clean read.
      send_a(24'h000200);
      k = 0;
      while (a_cnt != 41 && k < 1000) begin @(negedge clk); k++; end
      if (a_cnt != 41) fail("a_reach_rise40");
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ss", 32'(a_ss), 32'd1);
      chk("abort_sck", 32'(a_sck), 32'd0);
      chk("abort_resp_valid", 32'(a_resp_valid), 32'd0);
      chk("abort_busy", 32'(a_busy), 32'd0);
      chk("abort_req_ready", 32'(a_req_ready), 32'd1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      send_a(24'h000100);
      wait_idle_a();

      send_b(24'h000100);
      send_b(24'($urandom));

      // Random traffic: requests during busy must be ignored, backpressure is random.
      repeat (3000) begin
         @(negedge clk);
         a_req_valid = ($urandom_range(0, 3) == 0);
         a_req_addr  = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(24'h0000F8, 24'h000108))
                                                   : 24'($urandom);
      end
      @(negedge clk);
      a_req_valid = 1'b0;
      wait_idle_a();

      chk("a_bad_cmd_frames", a_bad_cmd, 0);
      chk("b_bad_cmd_frames", b_bad_cmd, 0);
      chk("a_pin_violations", a_pin_viol, 0);
      chk("b_pin_violations", b_pin_viol, 0);
      chk("a_queue_drained", a_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
